// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatch controller.
// Holding-register states and channel-selection mode codes.
package demux_dispatch_ctrl_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/demux_dispatch_ctrl_rr_pick4.sv
// Circular first-enabled search over 4 channels.
// Starts at ptr, wraps 3 -> 0.
module rr_pick4
  import demux_dispatch_ctrl_pkg::*;
(
  input  logic [3:0] en,
  input  logic [1:0] ptr,
  output logic [1:0] pick,
  output logic       found
);

  logic [1:0] idx;

  // Scan from farthest offset down so the nearest enabled channel wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Sequencing controller for a 1-to-4 demux: one holding register,
// fixed or round-robin steering, per-channel dispatch counters.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_mode,
  input  logic [1:0]                cfg_sel,
  input  logic [3:0]                cfg_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic [3:0]                out_valid,
  input  logic [3:0]                out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [NUM_CH*CNT_W-1:0]   dispatch_cnt
);

  state_t           state;
  logic [1:0]       tgt;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] cnt [NUM_CH];

  logic [1:0] rr_sel;
  logic       rr_found;
  logic [1:0] cand;
  logic       cand_ok;
  logic       full;
  logic       fire;
  logic       accept;

  rr_pick4 u_pick (
    .en    (cfg_en),
    .ptr   (rr_ptr),
    .pick  (rr_sel),
    .found (rr_found)
  );

  always_comb begin
    cand    = cfg_sel;
    cand_ok = cfg_en[cfg_sel];
    if (cfg_mode == MODE_RR) begin
      cand    = rr_sel;
      cand_ok = rr_found;
    end
  end

  assign full     = (state == ST_FULL);
  assign fire     = full && out_ready[tgt];
  assign in_ready = rst_n && cand_ok && (!full || fire);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid = '0;
    if (full) out_valid[tgt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      tgt      <= '0;
      rr_ptr   <= '0;
      out_data <= '0;
    end else if (accept) begin
      state    <= ST_FULL;
      tgt      <= cand;
      out_data <= in_data;
      if (cfg_mode == MODE_RR) rr_ptr <= cand + 2'd1;
    end else if (fire) begin
      state <= ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (fire) begin
      cnt[tgt] <= cnt[tgt] + CNT_W'(1);
    end
  end

  always_comb begin
    dispatch_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dispatch_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: vector table, directed sequences,
// and a cycle model with an expected-output queue.
module tb_demux_dispatch_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_mode;
  logic [1:0]   cfg_sel;
  logic [3:0]   cfg_en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;
  logic [4*CW-1:0] dispatch_cnt;

  int checks = 0;
  int errors = 0;

  demux_dispatch_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_mode     (cfg_mode),
    .cfg_sel      (cfg_sel),
    .cfg_en       (cfg_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .dispatch_cnt (dispatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] ov;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];

  logic       m_full;
  logic [1:0] m_tgt;
  logic [7:0] m_data;
  logic [1:0] m_ptr;
  logic [3:0] m_cnt [4];

  always @(negedge clk) begin
    logic [3:0]  exp_ov;
    logic [15:0] exp_cnt;
    logic        m_fire, c_ok, exp_ir;
    logic [1:0]  c_ch, idx;
    exp_t        e;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      m_full = 1'b0; m_tgt = '0; m_data = '0; m_ptr = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      q.delete();
    end else begin
      exp_ov = m_full ? (4'd1 << m_tgt) : 4'd0;
      chk("mon_out_valid", 32'(out_valid), 32'(exp_ov));
      if (m_full) chk("mon_out_data", 32'(out_data), 32'(m_data));
      for (int i = 0; i < 4; i++) exp_cnt[i*4 +: 4] = m_cnt[i];
      chk("mon_cnt", 32'(dispatch_cnt), 32'(exp_cnt));
      m_fire = m_full && out_ready[m_tgt];
      c_ok = 1'b0;
      c_ch = '0;
      if (cfg_mode) begin
        for (int k = 0; k < 4; k++) begin
          idx = m_ptr + 2'(k);
          if (!c_ok && cfg_en[idx]) begin
            c_ok = 1'b1;
            c_ch = idx;
          end
        end
      end else begin
        c_ch = cfg_sel;
        c_ok = cfg_en[cfg_sel];
      end
      exp_ir = c_ok && (!m_full || m_fire);
      chk("mon_in_ready", 32'(in_ready), 32'(exp_ir));
      if (|(out_valid & out_ready)) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_fire", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_fire_ch", 32'(out_valid), 32'(e.ov));
          chk("sb_fire_data", 32'(out_data), 32'(e.d));
        end
      end
      if (m_fire) m_cnt[m_tgt] = m_cnt[m_tgt] + 4'd1;
      if (in_valid && exp_ir) begin
        e.ov = 4'd1 << c_ch;
        e.d  = in_data;
        q.push_back(e);
        m_full = 1'b1;
        m_tgt  = c_ch;
        m_data = in_data;
        if (cfg_mode) m_ptr = c_ch + 2'd1;
      end else if (m_fire) begin
        m_full = 1'b0;
      end
    end
  end

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] en;
    logic [7:0] data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs [6];

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_one(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] t3 [4];
    vecs[0] = '{1'b0, 2'd2, 4'hF, 8'hA5, 2'd2};
    vecs[1] = '{1'b0, 2'd0, 4'hF, 8'h3C, 2'd0};
    vecs[2] = '{1'b0, 2'd3, 4'h8, 8'hC3, 2'd3};
    vecs[3] = '{1'b1, 2'd0, 4'h4, 8'h5A, 2'd2};
    vecs[4] = '{1'b1, 2'd3, 4'h1, 8'h99, 2'd0};
    vecs[5] = '{1'b0, 2'd1, 4'h2, 8'h66, 2'd1};
    t3[0] = 2'd1; t3[1] = 2'd3; t3[2] = 2'd1; t3[3] = 2'd3;

    cfg_mode = 1'b0; cfg_sel = '0; cfg_en = '0;
    in_valid = 1'b0; in_data = '0; out_ready = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_cnt", 32'(dispatch_cnt), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-word vectors
    out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cfg_mode = vecs[i].mode;
      cfg_sel  = vecs[i].sel;
      cfg_en   = vecs[i].en;
      send_one(vecs[i].data);
      chk("vec_out_valid", 32'(out_valid), 32'(4'd1 << vecs[i].exp_ch));
      chk("vec_out_data", 32'(out_data), 32'(vecs[i].data));
      @(posedge clk); #1;
      if (i == 0) chk("t1_cnt", 32'(dispatch_cnt), 32'h0100);
    end
    chk("vec_cnt_total", 32'(dispatch_cnt), 32'h1212);

    // RR back-to-back over all channels
    do_reset();
    cfg_mode = 1'b1; cfg_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      #1;
      chk("t2_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("t2_ch", 32'(out_valid), 32'(4'd1 << (i % 4)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2_cnt", 32'(dispatch_cnt), 32'h1112);

    // RR over sparse mask
    cfg_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(i);
      @(posedge clk); #1;
      chk("t3_ch", 32'(out_valid), 32'(4'd1 << t3[i]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // stall on channel 1 while cfg_sel moves to 3
    cfg_mode = 1'b0; cfg_sel = 2'd1; cfg_en = 4'hF;
    out_ready = 4'b1101;
    send_one(8'h77);
    in_valid = 1'b1;
    in_data  = 8'h88;
    cfg_sel  = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_out_valid", 32'(out_valid), 32'b0010);
      chk("t4_out_data", 32'(out_data), 32'h77);
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    #1;
    chk("t4_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_next_ch", 32'(out_valid), 32'b1000);
    chk("t4_next_data", 32'(out_data), 32'h88);
    @(posedge clk); #1;

    // no enabled channel: never ready
    cfg_en = 4'h0;
    in_valid = 1'b1;
    for (int m = 0; m < 2; m++) begin
      cfg_mode = m[0];
      for (int i = 0; i < 5; i++) begin
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;

    // counter wrap with 4-bit counters
    do_reset();
    cfg_mode = 1'b0; cfg_sel = 2'd0; cfg_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_wrap_cnt", 32'(dispatch_cnt), 32'h0001);

    // async reset while holding a word on channel 2
    cfg_sel = 2'd2;
    out_ready = 4'h0;
    send_one(8'hE1);
    chk("t6_full", 32'(out_valid), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_cnt", 32'(dispatch_cnt), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_mode = 1'b1; cfg_en = 4'hF; out_ready = 4'hF;
    send_one(8'h42);
    chk("t6_rr_first", 32'(out_valid), 32'b0001);
    chk("t6_rr_data", 32'(out_data), 32'h42);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
